// File: rtl/mem_ctrl_if.sv
// Requester and RAM-side signals of the byte-wide memory controller.
// Handshake: a requester holds its request (if_req, or memctl_op != NOP) stable
// until its one-cycle fin pulse, then drops or changes it on that same edge.
interface mem_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_fin;
  logic [31:0]       if_data;
  logic [1:0]        memctl_op;
  logic [1:0]        memctl_len;
  logic [ADDR_W-1:0] memctl_addr;
  logic [31:0]       memctl_data;
  logic              memctl_fin;
  logic [31:0]       memctl_out;
  logic [ADDR_W-1:0] ram_a;
  logic [7:0]        ram_dout;
  logic              ram_wr;
  logic [7:0]        ram_din;

  modport master (
    output if_req, if_addr, memctl_op, memctl_len, memctl_addr, memctl_data, ram_din,
    input  if_fin, if_data, memctl_fin, memctl_out, ram_a, ram_dout, ram_wr
  );

  modport slave (
    input  if_req, if_addr, memctl_op, memctl_len, memctl_addr, memctl_data, ram_din,
    output if_fin, if_data, memctl_fin, memctl_out, ram_a, ram_dout, ram_wr
  );
endinterface

// File: rtl/mem_ctrl.sv
// Arbiter/sequencer splitting IF and MEM requests into serial byte RAM accesses.
// Optional MEMCTL_RR_EN: round-robin arbitration instead of fixed MEM-over-IF.
module mem_ctrl #(
  parameter int ADDR_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       rdy_in,
  mem_ctrl_if.slave  bus,
  output logic [1:0] dbg_state
);
  localparam logic [1:0] OP_LOAD = 2'd1;
  localparam logic [1:0] OP_SAVE = 2'd2;
  localparam logic [2:0] LAT3    = 3'(RD_LAT);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_DONE} state_t;

  state_t            state;
  logic              owner_mem;
  logic [ADDR_W-1:0] addr;
  logic [2:0]        n;
  logic [2:0]        i;
  logic [31:0]       wdata;
  logic [31:0]       rbuf;
  logic [31:0]       rbuf_cap;
  logic [7:0]        din_hold;
  logic              rdy_q;
  logic              if_fin_q, memctl_fin_q, wr_q;
  logic [31:0]       if_data_q, memctl_out_q;
  logic [ADDR_W-1:0] ram_a_q;
  logic [7:0]        ram_dout_q;

  logic              mem_pend, grant_mem, any_req;
  logic [2:0]        req_n, i_nx;
  logic [1:0]        cap_idx;
  logic [ADDR_W-1:0] req_addr;
  logic [7:0]        din_eff, wbyte;

  assign mem_pend = ((bus.memctl_op == OP_LOAD) || (bus.memctl_op == OP_SAVE)) &&
                    (bus.memctl_len != 2'd3);
  assign any_req  = mem_pend || bus.if_req;

`ifdef MEMCTL_RR_EN
  logic last_if;
  assign grant_mem = mem_pend && (!bus.if_req || last_if);
`else
  assign grant_mem = mem_pend;
`endif

  assign req_addr = grant_mem ? bus.memctl_addr : bus.if_addr;
  assign i_nx     = i + 3'd1;
  assign cap_idx  = 2'(i - LAT3);
  assign wbyte    = wdata[{i_nx[1:0], 3'b000} +: 8];

  // The RAM keeps reading while frozen, so the byte that was due at the first
  // frozen edge is parked in din_hold and used on the first edge after resuming.
  assign din_eff  = rdy_q ? bus.ram_din : din_hold;

  always_comb begin
    req_n = 3'd4;
    if (grant_mem) begin
      case (bus.memctl_len)
        2'd0:    req_n = 3'd1;
        2'd1:    req_n = 3'd2;
        default: req_n = 3'd4;
      endcase
    end
  end

  always_comb begin
    rbuf_cap = rbuf;
    rbuf_cap[{cap_idx, 3'b000} +: 8] = din_eff;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state        <= S_IDLE;
      owner_mem    <= 1'b0;
      addr         <= '0;
      n            <= 3'd0;
      i            <= 3'd0;
      wdata        <= 32'h0;
      rbuf         <= 32'h0;
      din_hold     <= 8'h0;
      rdy_q        <= 1'b1;
      if_fin_q     <= 1'b0;
      memctl_fin_q <= 1'b0;
      wr_q         <= 1'b0;
      if_data_q    <= 32'h0;
      memctl_out_q <= 32'h0;
      ram_a_q      <= '0;
      ram_dout_q   <= 8'h0;
`ifdef MEMCTL_RR_EN
      last_if      <= 1'b1;
`endif
    end else begin
      rdy_q <= rdy_in;
      if (rdy_q && !rdy_in) din_hold <= bus.ram_din;
      if (rdy_in) begin
        case (state)
          S_IDLE: begin
            if (any_req) begin
              owner_mem <= grant_mem;
              addr      <= req_addr;
              n         <= req_n;
              i         <= 3'd0;
              wdata     <= bus.memctl_data;
              rbuf      <= 32'h0;
              ram_a_q   <= req_addr;
`ifdef MEMCTL_RR_EN
              last_if   <= !grant_mem;
`endif
              if (grant_mem && (bus.memctl_op == OP_SAVE)) begin
                ram_dout_q <= bus.memctl_data[7:0];
                wr_q       <= 1'b1;
                state      <= S_WR;
              end else begin
                state      <= S_RD;
              end
            end
          end
          S_RD: begin
            if (i >= LAT3) rbuf <= rbuf_cap;
            if ((i >= LAT3) && (i == n + LAT3 - 3'd1)) begin
              state <= S_DONE;
              if (owner_mem) begin
                memctl_fin_q <= 1'b1;
                memctl_out_q <= rbuf_cap;
              end else begin
                if_fin_q  <= 1'b1;
                if_data_q <= rbuf_cap;
              end
            end else begin
              i <= i_nx;
              if (i_nx < n) ram_a_q <= addr + ADDR_W'(i_nx);
            end
          end
          S_WR: begin
            if (i_nx < n) begin
              i          <= i_nx;
              ram_a_q    <= addr + ADDR_W'(i_nx);
              ram_dout_q <= wbyte;
              wr_q       <= 1'b1;
            end else begin
              wr_q         <= 1'b0;
              memctl_fin_q <= 1'b1;
              state        <= S_DONE;
            end
          end
          default: begin
            if_fin_q     <= 1'b0;
            memctl_fin_q <= 1'b0;
            wr_q         <= 1'b0;
            state        <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.if_fin     = if_fin_q;
  assign bus.if_data    = if_data_q;
  assign bus.memctl_fin = memctl_fin_q;
  assign bus.memctl_out = memctl_out_q;
  assign bus.ram_a      = ram_a_q;
  assign bus.ram_dout   = ram_dout_q;
  assign bus.ram_wr     = wr_q & rdy_in;
  assign dbg_state      = state;
endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: byte RAM model, write scoreboard, latency/data checks.
module tb_mem_ctrl;
  localparam logic [1:0] NOP = 2'd0, LOAD = 2'd1, SAVE = 2'd2;
  localparam logic [1:0] BYTE = 2'd0, HALF = 2'd1, WORD = 2'd2;

  logic       clk = 1'b0;
  logic       rst;
  logic       rdy;
  logic [1:0] dbg_state;

  mem_ctrl_if b();

  mem_ctrl dut (
    .clk_in    (clk),
    .rst_in    (rst),
    .rdy_in    (rdy),
    .bus       (b),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // RAM model: one-cycle read latency, write on ram_wr
  logic [7:0] ram [0:1023];
  bit         init_done;

  always @(posedge clk) begin
    if (rst && !init_done) begin
      for (int k = 0; k < 1024; k++) ram[k] <= 8'h00;
      ram[10'h004] <= 8'h13; ram[10'h005] <= 8'h05;
      ram[10'h010] <= 8'h11; ram[10'h011] <= 8'h22;
      ram[10'h012] <= 8'h33; ram[10'h013] <= 8'h44;
      ram[10'h200] <= 8'h34; ram[10'h201] <= 8'h12;
      ram[10'h300] <= 8'hA5;
      ram[10'h3FE] <= 8'h78; ram[10'h3FF] <= 8'h56;
      ram[10'h000] <= 8'h34; ram[10'h001] <= 8'h12;
      init_done <= 1'b1;
    end else if (b.ram_wr) begin
      ram[b.ram_a[9:0]] <= b.ram_dout;
    end
    b.ram_din <= ram[b.ram_a[9:0]];
  end

  // write monitor log
  logic [39:0] wr_log [0:63];
  int          wr_cnt = 0;

  always @(negedge clk) begin
    if (b.ram_wr && wr_cnt < 64) begin
      wr_log[wr_cnt] <= {b.ram_a, b.ram_dout};
      wr_cnt         <= wr_cnt + 1;
    end
  end

  // scoreboard
  logic [39:0] exp_q[$];
  int          rd_idx = 0;
  int          n_chk  = 0;
  int          n_fail = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic mem_req(input logic [1:0] op, input logic [1:0] len,
                         input logic [31:0] a, input logic [31:0] d);
    b.memctl_op   = op;
    b.memctl_len  = len;
    b.memctl_addr = a;
    b.memctl_data = d;
  endtask

  task automatic if_request(input logic req, input logic [31:0] a);
    b.if_req  = req;
    b.if_addr = a;
  endtask

  task automatic wait_fin(output int cyc, output bit got_mem);
    cyc = 0;
    while (!(b.if_fin || b.memctl_fin) && cyc < 40) begin
      tick();
      cyc++;
    end
    chk("fin_seen", 32'(b.if_fin | b.memctl_fin), 32'd1);
    chk("fin_excl", 32'(b.if_fin & b.memctl_fin), 32'd0);
    got_mem = b.memctl_fin;
  endtask

  task automatic check_writes();
    logic [39:0] e;
    chk("wr_count", 32'(wr_cnt - rd_idx), 32'(exp_q.size()));
    while (rd_idx < wr_cnt && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("wr_addr", wr_log[rd_idx][39:8], e[39:8]);
      chk("wr_byte", {24'h0, wr_log[rd_idx][7:0]}, {24'h0, e[7:0]});
      rd_idx++;
    end
    exp_q.delete();
    rd_idx = wr_cnt;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    bit got;
    bit exp_mem;

    rst = 1'b1;
    rdy = 1'b1;
    if_request(1'b0, 32'h0);
    mem_req(NOP, BYTE, 32'h0, 32'h0);
    tick();
    tick();
    chk("rst_state",      32'(dbg_state),    32'd0);
    chk("rst_if_fin",     32'(b.if_fin),     32'd0);
    chk("rst_memctl_fin", 32'(b.memctl_fin), 32'd0);
    chk("rst_ram_wr",     32'(b.ram_wr),     32'd0);
    chk("rst_if_data",    b.if_data,         32'h0);
    chk("rst_memctl_out", b.memctl_out,      32'h0);
    chk("rst_ram_a",      b.ram_a,           32'h0);
    chk("rst_ram_dout",   32'(b.ram_dout),   32'h0);
    rst = 1'b0;
    tick();

    // IF word fetch at 0x4
    if_request(1'b1, 32'h4);
    tick();
    chk("if_ram_a", b.ram_a, 32'h4);
    wait_fin(cyc, got);
    chk("if_lat",   32'(cyc), 32'd5);
    chk("if_owner", 32'(got), 32'd0);
    chk("if_data",  b.if_data, 32'h0000_0513);
    if_request(1'b0, 32'h0);
    tick();
    chk("if_fin_pulse", 32'(b.if_fin), 32'd0);
    chk("if_idle",      32'(dbg_state), 32'd0);

    // MEM save word at 0x100
    exp_q.push_back({32'h100, 8'hEF});
    exp_q.push_back({32'h101, 8'hBE});
    exp_q.push_back({32'h102, 8'hAD});
    exp_q.push_back({32'h103, 8'hDE});
    mem_req(SAVE, WORD, 32'h100, 32'hDEAD_BEEF);
    tick();
    wait_fin(cyc, got);
    chk("save_lat",   32'(cyc), 32'd4);
    chk("save_owner", 32'(got), 32'd1);
    mem_req(NOP, BYTE, 32'h0, 32'h0);
    tick();
    chk("save_fin_pulse", 32'(b.memctl_fin), 32'd0);
    chk("save_wr_off",    32'(b.ram_wr),     32'd0);
    check_writes();
    chk("save_ram_103", 32'(ram[10'h103]), 32'hDE);

    // MEM half load at 0x200
    mem_req(LOAD, HALF, 32'h200, 32'h0);
    tick();
    wait_fin(cyc, got);
    chk("half_lat",     32'(cyc), 32'd3);
    chk("half_owner",   32'(got), 32'd1);
    chk("half_data",    b.memctl_out, 32'h0000_1234);
    chk("half_if_hold", b.if_data,    32'h0000_0513);
    mem_req(NOP, BYTE, 32'h0, 32'h0);
    tick();

    // word load wrapping past the top of the address space
    mem_req(LOAD, WORD, 32'hFFFF_FFFE, 32'h0);
    tick();
    wait_fin(cyc, got);
    chk("wrap_lat",  32'(cyc), 32'd5);
    chk("wrap_data", b.memctl_out, 32'h1234_5678);
    mem_req(NOP, BYTE, 32'h0, 32'h0);
    tick();

    // len=3 is not a request
    mem_req(LOAD, 2'd3, 32'h200, 32'h0);
    tick();
    tick();
    chk("len3_idle", 32'(dbg_state),    32'd0);
    chk("len3_fin",  32'(b.memctl_fin), 32'd0);
    mem_req(NOP, BYTE, 32'h0, 32'h0);
    tick();

    // rdy low for 3 cycles in the middle of a word load
    mem_req(LOAD, WORD, 32'h10, 32'h0);
    tick();
    tick();
    tick();
    rdy = 1'b0;
    tick();
    tick();
    tick();
    chk("frz_no_fin", 32'(b.memctl_fin), 32'd0);
    rdy = 1'b1;
    wait_fin(cyc, got);
    chk("frz_lat",  32'(cyc + 5), 32'd8);
    chk("frz_data", b.memctl_out, 32'h4433_2211);
    mem_req(NOP, BYTE, 32'h0, 32'h0);
    tick();

    // reset after two bytes of a word save
    exp_q.push_back({32'h180, 8'h0D});
    exp_q.push_back({32'h181, 8'hF0});
    mem_req(SAVE, WORD, 32'h180, 32'hCAFE_F00D);
    tick();
    tick();
    rst = 1'b1;
    mem_req(NOP, BYTE, 32'h0, 32'h0);
    tick();
    chk("rstmid_wr",    32'(b.ram_wr),     32'd0);
    chk("rstmid_state", 32'(dbg_state),    32'd0);
    chk("rstmid_fin",   32'(b.memctl_fin), 32'd0);
    rst = 1'b0;
    tick();
    tick();
    chk("rstmid_fin_later", 32'(b.memctl_fin), 32'd0);
    check_writes();
    chk("rstmid_ram_182", 32'(ram[10'h182]), 32'h00);

    // simultaneous requests held across several grants
    if_request(1'b1, 32'h10);
    mem_req(LOAD, BYTE, 32'h300, 32'h0);
    for (int g = 0; g < 3; g++) begin
`ifdef MEMCTL_RR_EN
      exp_mem = (g % 2 == 0);
`else
      exp_mem = 1'b1;
`endif
      tick();
      wait_fin(cyc, got);
      chk("tie_owner", 32'(got), 32'(exp_mem));
      chk("tie_lat",   32'(cyc), exp_mem ? 32'd2 : 32'd5);
      chk("tie_data",  exp_mem ? b.memctl_out : b.if_data,
                       exp_mem ? 32'h0000_00A5 : 32'h4433_2211);
      tick();
      chk("tie_fin_low", 32'(b.if_fin | b.memctl_fin), 32'd0);
    end
    mem_req(NOP, BYTE, 32'h0, 32'h0);
    tick();
    wait_fin(cyc, got);
    chk("tie_if_owner", 32'(got), 32'd0);
    chk("tie_if_data",  b.if_data, 32'h4433_2211);
    if_request(1'b0, 32'h0);
    tick();
    chk("end_idle", 32'(dbg_state), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
